// File: rtl/ft601_rd_fifo.sv
// FT601 read-side FIFO: qualifies RD# strobes into block-RAM writes and serves them in FWFT or standard-read mode.
// Latency: FWFT shows an accepted word 2 edges later; standard mode returns rd_data/rd_valid 1 edge after the pop.
// Backpressure: registered wr_full drops writes (sticky overflow); ft_ready asks for a full burst of free space.
module ft601_rd_fifo #(
    parameter int DATA_W      = 36,
    parameter int ADDR_W      = 12,
    parameter int FWFT        = 1,
    parameter int BURST_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ft_rxf_n,
    input  logic              ft_rd_n,
    input  logic              wr_ce,
    output logic              wr_full,
    output logic              wr_afull,
    output logic              ft_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_en,
    input  logic              rd_ce,
    output logic              rd_empty,
    output logic              rd_aempty,
    input  logic [ADDR_W:0]   afull_thresh,
    input  logic [ADDR_W:0]   aempty_thresh,
    output logic [ADDR_W:0]   level,
    input  logic              flush,
    input  logic              clr_err,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] BURST_C = (ADDR_W+1)'(BURST_WORDS);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    // Pointers carry one extra bit so a completely full RAM is distinguishable from empty.
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   ram_cnt;
    logic [ADDR_W:0]   level_q;
    logic [ADDR_W:0]   level_next;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] out_q;
    logic              s1_vld;
    logic              vld_q;
    logic              empty_q;
    logic              full_q;
    logic              afull_q;
    logic              aempty_q;
    logic              ready_q;
    logic              ovf_q;
    logic              unf_q;

    logic wr_req;
    logic rd_req;
    logic accept;
    logic pop;
    logic ram_rd;
    logic s1_moves;
    logic ovf_evt;
    logic unf_evt;

    always_comb begin
        wr_req   = !ft_rxf_n && !ft_rd_n && wr_ce;
        rd_req   = rd_en && rd_ce;
        ram_cnt  = wr_ptr - rd_ptr;
        accept   = wr_req && !full_q && !flush;
        ovf_evt  = wr_req && full_q && !flush;
        unf_evt  = rd_req && rd_empty && !flush;
        pop      = 1'b0;
        s1_moves = 1'b0;
        ram_rd   = 1'b0;
        if (FWFT != 0) begin
            // RAM output register (s1) refills whenever it is empty or hands its word to the output stage.
            pop      = rd_req && vld_q && !flush;
            s1_moves = s1_vld && (!vld_q || pop);
            ram_rd   = (ram_cnt != '0) && (!s1_vld || s1_moves) && !flush;
        end else begin
            pop      = rd_req && !empty_q && !flush;
            ram_rd   = pop;
        end

        level_next = level_q;
        if (flush) begin
            level_next = '0;
        end else if (accept && !pop) begin
            level_next = level_q + ONE;
        end else if (pop && !accept) begin
            level_next = level_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_q <= '0;
        end else if (ram_rd) begin
            ram_q <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else if (s1_moves) begin
            out_q <= ram_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            s1_vld <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + ONE;
            end
            if (FWFT != 0) begin
                if (ram_rd) begin
                    s1_vld <= 1'b1;
                end else if (s1_moves) begin
                    s1_vld <= 1'b0;
                end
                if (s1_moves) begin
                    vld_q <= 1'b1;
                end else if (pop) begin
                    vld_q <= 1'b0;
                end
            end else begin
                s1_vld <= 1'b0;
                vld_q  <= pop;
            end
        end
    end

    // All status flags are computed from level_next so they move on the same edge as level.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= (afull_thresh == '0);
            aempty_q <= 1'b1;
            ready_q  <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            level_q  <= level_next;
            full_q   <= (level_next == DEPTH_C);
            afull_q  <= (level_next >= afull_thresh);
            aempty_q <= (level_next <= aempty_thresh);
            ready_q  <= ((DEPTH_C - level_next) >= BURST_C);
            empty_q  <= (level_next == '0);
            ovf_q    <= ovf_evt || (ovf_q && !clr_err);
            unf_q    <= unf_evt || (unf_q && !clr_err);
        end
    end

    assign rd_data   = (FWFT != 0) ? out_q : ram_q;
    assign rd_valid  = vld_q;
    assign rd_empty  = (FWFT != 0) ? !vld_q : empty_q;
    assign wr_full   = full_q;
    assign wr_afull  = afull_q;
    assign rd_aempty = aempty_q;
    assign ft_ready  = ready_q;
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
